// File: rtl/fifo_model_pkg.sv
// Shared sizing constants for the fifo_model block.
// The default word width, depth and pointer width live here so the top, the
// storage sub-module and any bench agree on one set of numbers.
package fifo_model_pkg;

    localparam int DEF_FWIDTH   = 32;
    localparam int DEF_FDEPTH   = 8;
    localparam int DEF_FCWIDTH  = 3;
    // Occupancy needs one more bit than a pointer to represent "full".
    localparam int DEF_CNTWIDTH = DEF_FCWIDTH + 1;

endpackage

// File: rtl/fifo_model_mem.sv
// Register-file storage for fifo_model: one synchronous write port and one
// asynchronous read port. The read data is registered by the parent, which
// gives the one-cycle read latency seen on F_Data.
module fifo_model_mem
    import fifo_model_pkg::*;
#(
    parameter int WIDTH  = DEF_FWIDTH,
    parameter int DEPTH  = DEF_FDEPTH,
    parameter int AWIDTH = DEF_FCWIDTH
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_model.sv
// Synchronous FIFO with active-low controls and decoded occupancy flags.
// Handshake: a write is accepted on a rising Clk when FInN=0 and the FIFO is
// not full; a read is accepted when FOutN=0 and the FIFO is not empty. Both
// fullness tests use the count before the edge, so a write to a full FIFO is
// rejected even if a read happens on the same edge. Rejected requests change
// nothing. The read word appears on F_Data one cycle after the read edge.
// Optional feature: define FIFO_MODEL_ERR_EN to add the sticky overflow and
// underflow outputs F_OvfN / F_UdfN.
module fifo_model
    import fifo_model_pkg::*;
#(
    parameter int FWIDTH  = DEF_FWIDTH,
    parameter int FDEPTH  = DEF_FDEPTH,
    parameter int FCWIDTH = DEF_FCWIDTH
) (
    input  logic              Clk,
    input  logic              RstN,
    input  logic              FClrN,
    input  logic              FInN,
    input  logic              FOutN,
    input  logic [FWIDTH-1:0] Data_In,
    output logic [FWIDTH-1:0] F_Data,
    output logic              F_FullN,
    output logic              F_EmptyN,
    output logic              F_FirstN,
    output logic              F_LastN,
    output logic              F_SLastN
`ifdef FIFO_MODEL_ERR_EN
    ,
    output logic              F_OvfN,
    output logic              F_UdfN
`endif
);

    localparam int CW = FCWIDTH + 1;

    localparam logic [FCWIDTH-1:0] PTR_ONE    = {{(FCWIDTH-1){1'b0}}, 1'b1};
    localparam logic [FCWIDTH-1:0] PTR_LAST   = FCWIDTH'(FDEPTH - 1);
    localparam logic [CW-1:0]      CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_FULL   = CW'(FDEPTH);
    localparam logic [CW-1:0]      CNT_LAST   = CW'(FDEPTH - 1);
    localparam logic [CW-1:0]      CNT_SLAST  = CW'(FDEPTH - 2);

    logic [FCWIDTH-1:0] wr_ptr;
    logic [FCWIDTH-1:0] rd_ptr;
    logic [CW-1:0]      count;
    logic [FCWIDTH-1:0] wr_ptr_nxt;
    logic [FCWIDTH-1:0] rd_ptr_nxt;
    logic [CW-1:0]      count_nxt;
    logic [FWIDTH-1:0]  mem_rd_data;
    logic               is_full;
    logic               is_empty;
    logic               wr_ok;
    logic               rd_ok;
    logic               mem_we;

    assign is_full  = (count == CNT_FULL);
    assign is_empty = (count == '0);
    assign wr_ok    = !FInN  && !is_full;
    assign rd_ok    = !FOutN && !is_empty;
    // Clear and reset win over a write, so storage is left untouched then.
    assign mem_we   = wr_ok && RstN && FClrN;

    // Pointer increments wrap at FDEPTH; occupancy follows the accepted ops.
    always_comb begin
        wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
        rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
        count_nxt  = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and read data register; reset then clear take priority.
    always_ff @(posedge Clk) begin
        if (!RstN || !FClrN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            F_Data <= '0;
        end else begin
            count <= count_nxt;
            if (wr_ok) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_nxt;
                F_Data <= mem_rd_data;
            end
        end
    end

    // Flags are pure decodes of the registered count.
    always_comb begin
        F_FullN  = !(count == CNT_FULL);
        F_EmptyN = !(count == '0);
        F_FirstN = !(count == CNT_ONE);
        F_LastN  = !(count == CNT_LAST);
        F_SLastN = !(count == CNT_SLAST);
    end

`ifdef FIFO_MODEL_ERR_EN
    // Sticky error flags: set by a rejected write or read, released by reset or clear.
    always_ff @(posedge Clk) begin
        if (!RstN || !FClrN) begin
            F_OvfN <= 1'b1;
            F_UdfN <= 1'b1;
        end else begin
            if (!FInN && is_full) begin
                F_OvfN <= 1'b0;
            end
            if (!FOutN && is_empty) begin
                F_UdfN <= 1'b0;
            end
        end
    end
`endif

    fifo_model_mem #(
        .WIDTH  (FWIDTH),
        .DEPTH  (FDEPTH),
        .AWIDTH (FCWIDTH)
    ) u_mem (
        .clk     (Clk),
        .wr_en   (mem_we),
        .wr_addr (wr_ptr),
        .wr_data (Data_In),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

endmodule

// File: tb/tb_fifo_model.sv
// Bench for fifo_model: a directed vector table, hand-written multi-cycle
// sequences, and a randomized phase, all scored against a queue-based model.
module tb_fifo_model;

    localparam int W = 32;
    localparam int D = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fclrn = 1'b1;
    logic          finn = 1'b1;
    logic          foutn = 1'b1;
    logic [W-1:0]  din = '0;
    logic [W-1:0]  f_data;
    logic          f_full_n, f_empty_n, f_first_n, f_last_n, f_slast_n;
`ifdef FIFO_MODEL_ERR_EN
    logic          f_ovf_n, f_udf_n;
    logic          m_ovf_n = 1'b1;
    logic          m_udf_n = 1'b1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of stored words plus the last word read.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_data = '0;

    fifo_model dut (
        .Clk      (clk),
        .RstN     (rstn),
        .FClrN    (fclrn),
        .FInN     (finn),
        .FOutN    (foutn),
        .Data_In  (din),
        .F_Data   (f_data),
        .F_FullN  (f_full_n),
        .F_EmptyN (f_empty_n),
        .F_FirstN (f_first_n),
        .F_LastN  (f_last_n),
        .F_SLastN (f_slast_n)
`ifdef FIFO_MODEL_ERR_EN
        ,
        .F_OvfN   (f_ovf_n),
        .F_UdfN   (f_udf_n)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Flag check from an occupancy value stated by the caller.
    task automatic check_flags(input string tag, input int n);
        check({tag, ".full_n"},  W'(f_full_n),  W'(n != D));
        check({tag, ".empty_n"}, W'(f_empty_n), W'(n != 0));
        check({tag, ".first_n"}, W'(f_first_n), W'(n != 1));
        check({tag, ".last_n"},  W'(f_last_n),  W'(n != D - 1));
        check({tag, ".slast_n"}, W'(f_slast_n), W'(n != D - 2));
    endtask

    task automatic model_step(input logic r, input logic c, input logic wn, input logic rn,
                              input logic [W-1:0] d);
        bit do_wr;
        bit do_rd;
        if (!r || !c) begin
            exp_q.delete();
            m_data = '0;
`ifdef FIFO_MODEL_ERR_EN
            m_ovf_n = 1'b1;
            m_udf_n = 1'b1;
`endif
        end else begin
            do_wr = !wn && (exp_q.size() < D);
            do_rd = !rn && (exp_q.size() > 0);
`ifdef FIFO_MODEL_ERR_EN
            if (!wn && exp_q.size() == D) m_ovf_n = 1'b0;
            if (!rn && exp_q.size() == 0) m_udf_n = 1'b0;
`endif
            if (do_rd) m_data = exp_q.pop_front();
            if (do_wr) exp_q.push_back(d);
        end
    endtask

    // One clock: drive, let the edge happen, update the model, compare.
    task automatic cycle(input logic r, input logic c, input logic wn, input logic rn,
                         input logic [W-1:0] d);
        rstn = r; fclrn = c; finn = wn; foutn = rn; din = d;
        @(posedge clk);
        model_step(r, c, wn, rn, d);
        #1;
        check("model.data", f_data, m_data);
        check_flags("model", exp_q.size());
`ifdef FIFO_MODEL_ERR_EN
        check("model.ovf_n", W'(f_ovf_n), W'(m_ovf_n));
        check("model.udf_n", W'(f_udf_n), W'(m_udf_n));
`endif
        rstn = 1'b1; fclrn = 1'b1; finn = 1'b1; foutn = 1'b1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b1, 1'b1, 1'b1, '0);
    endtask

    typedef struct {
        string        name;
        logic         r, c, wn, rn;
        logic [W-1:0] d;
        int           exp_cnt;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] words[D];
    logic [W-1:0] outs[$];

    function automatic vec_t mk(input string n, input logic r, input logic c, input logic wn,
                                input logic rn, input logic [W-1:0] d, input int cnt,
                                input logic [W-1:0] ed);
        vec_t v;
        v.name = n; v.r = r; v.c = c; v.wn = wn; v.rn = rn; v.d = d;
        v.exp_cnt = cnt; v.exp_data = ed;
        return v;
    endfunction

    initial begin
        foreach (words[i]) words[i] = $urandom;

        // Directed table: reset, clear, fill, overflow attempt, drain, underflow, single word.
        tbl.push_back(mk("reset",  1'b0, 1'b1, 1'b1, 1'b1, '0, 0, '0));
        tbl.push_back(mk("clear",  1'b1, 1'b0, 1'b1, 1'b1, '0, 0, '0));
        for (int i = 0; i < D; i++)
            tbl.push_back(mk($sformatf("wr%0d", i + 1), 1'b1, 1'b1, 1'b0, 1'b1, words[i], i + 1, '0));
        tbl.push_back(mk("wr_full", 1'b1, 1'b1, 1'b0, 1'b1, 32'hCDABEFDC, D, '0));
        for (int i = 0; i < D; i++)
            tbl.push_back(mk($sformatf("rd%0d", i + 1), 1'b1, 1'b1, 1'b1, 1'b0, '0, D - 1 - i, words[i]));
        tbl.push_back(mk("rd_empty", 1'b1, 1'b1, 1'b1, 1'b0, '0, 0, words[D - 1]));
        tbl.push_back(mk("wr_one",   1'b1, 1'b1, 1'b0, 1'b1, 32'h98765432, 1, words[D - 1]));
        tbl.push_back(mk("rd_one",   1'b1, 1'b1, 1'b1, 1'b0, '0, 0, 32'h98765432));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].c, tbl[i].wn, tbl[i].rn, tbl[i].d);
            check({tbl[i].name, ".data"}, f_data, tbl[i].exp_data);
            check_flags(tbl[i].name, tbl[i].exp_cnt);
            idle();
        end

        // Wrapped fill: pointers now sit at 1, so this fill and drain cross the wrap.
        for (int i = 0; i < D - 1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, words[i] ^ 32'h5A5A_0000);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h12345678);
        check("wrap.full_n", W'(f_full_n), W'(1'b0));
        outs.delete();
        for (int i = 0; i < D; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
            outs.push_back(f_data);
        end
        for (int i = 0; i < D - 1; i++)
            check($sformatf("wrap.out%0d", i), outs[i], words[i] ^ 32'h5A5A_0000);
        check("wrap.last", outs[D - 1], 32'h12345678);

        // Clear in the middle of a fill.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, $urandom);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, $urandom);
        check("midclr.empty_n", W'(f_empty_n), W'(1'b0));
        check("midclr.data", f_data, '0);

        // Full with simultaneous read and write: the write must be refused.
        for (int i = 0; i < D; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hA000_0000 + i);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        check("fullrw.data", f_data, 32'hA000_0000);
        check_flags("fullrw", D - 1);
        for (int i = 0; i < D - 1; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("fullrw.tail", f_data, 32'hA000_0007);

        // Simultaneous read and write in the middle keeps occupancy.
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0011);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0022);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0033);
        check("rw.data", f_data, 32'h0000_0011);
        check_flags("rw", 2);

        // Reset mid-operation discards everything, even with requests pending.
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0044);
        check_flags("midrst", 0);
        check("midrst.data", f_data, '0);

        // Randomized phase with a drifting write bias to reach both full and empty.
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            cycle(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) != 0),
                  !($urandom_range(0, 99) < bias), !($urandom_range(0, 99) < (100 - bias)),
                  $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
